// File: rtl/multiword_add_sched_pkg.sv
// rtl/multiword_add_sched_pkg.sv - FSM state encoding and width helper for the shared wide adder
package multiword_add_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Index width for a count of n items; a single item still needs one bit.
    function automatic int min_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/multiword_add_sched_if.sv
// rtl/multiword_add_sched_if.sv - request/response bundle between requesters and the adder scheduler
interface multiword_add_sched_if
    import multiword_add_sched_pkg::*;
#(
    parameter int CHUNK_W    = 32,
    parameter int NUM_CHUNKS = 2,
    parameter int NUM_REQ    = 2
);
    localparam int ID_W = min_w(NUM_REQ);
    localparam int OP_W = NUM_CHUNKS * CHUNK_W;

    logic [NUM_REQ-1:0]      req_valid;
    logic [NUM_REQ-1:0]      req_ready;
    logic [NUM_REQ*OP_W-1:0] req_in1;
    logic [NUM_REQ*OP_W-1:0] req_in2;
    logic [NUM_REQ-1:0]      req_cin;
    logic                    resp_valid;
    logic                    resp_ready;
    logic [ID_W-1:0]         resp_id;
    logic [OP_W-1:0]         resp_sum;
    logic                    resp_cout;

    modport master (
        output req_valid, req_in1, req_in2, req_cin, resp_ready,
        input  req_ready, resp_valid, resp_id, resp_sum, resp_cout
    );

    modport slave (
        input  req_valid, req_in1, req_in2, req_cin, resp_ready,
        output req_ready, resp_valid, resp_id, resp_sum, resp_cout
    );

endinterface

// File: rtl/multiword_add_sched_adder.sv
// rtl/multiword_add_sched_adder.sv - the single shared chunk-wide adder
module adder_param #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};

endmodule

// File: rtl/multiword_add_sched.sv
// rtl/multiword_add_sched.sv - round-robin scheduler running wide adds chunk by chunk on one adder
module multiword_add_sched
    import multiword_add_sched_pkg::*;
#(
    parameter int CHUNK_W    = 32,
    parameter int NUM_CHUNKS = 2,
    parameter int NUM_REQ    = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    multiword_add_sched_if.slave bus
);

    localparam int ID_W  = min_w(NUM_REQ);
    localparam int CNT_W = min_w(NUM_CHUNKS);
    localparam int OP_W  = NUM_CHUNKS * CHUNK_W;

    state_t state_q, state_d;

    logic [ID_W-1:0]                      rr_q;
    logic [ID_W-1:0]                      id_q;
    logic [ID_W-1:0]                      grant;
    logic [ID_W-1:0]                      off;
    logic [ID_W:0]                        gsum;
    logic [NUM_REQ-1:0]                   rot;
    logic                                 any_valid;
    logic [NUM_CHUNKS-1:0][CHUNK_W-1:0]   a_q, b_q, sum_q;
    logic                                 cin_q, carry_q, cout_q;
    logic [CNT_W-1:0]                     cnt_q;
    logic                                 last_chunk;
    logic [CHUNK_W-1:0]                   add_sum;
    logic                                 add_cout;
    logic                                 add_cin;

    // Rotate so the slot after the last grant sits at bit 0, pick the lowest, rotate back.
    always_comb begin
        rot       = NUM_REQ'({bus.req_valid, bus.req_valid} >> ({1'b0, rr_q} + 1'b1));
        off       = '0;
        any_valid = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                off       = ID_W'(k);
                any_valid = 1'b1;
            end
        end
        gsum  = {1'b0, rr_q} + {1'b0, off} + 1'b1;
        grant = ID_W'((gsum >= (ID_W+1)'(NUM_REQ)) ? gsum - (ID_W+1)'(NUM_REQ) : gsum);
    end

    assign last_chunk = (cnt_q == CNT_W'(NUM_CHUNKS - 1));
    assign add_cin    = (cnt_q == '0) ? cin_q : carry_q;

    adder_param #(.WIDTH(CHUNK_W)) u_adder (
        .a    (a_q[cnt_q]),
        .b    (b_q[cnt_q]),
        .cin  (add_cin),
        .sum  (add_sum),
        .cout (add_cout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        bus.req_ready = '0;
        case (state_q)
            ST_IDLE: begin
                if (any_valid && !rst) begin
                    bus.req_ready = NUM_REQ'(1) << grant;
                    state_d       = ST_RUN;
                end
            end
            ST_RUN:  if (last_chunk) state_d = ST_DONE;
            ST_DONE: if (bus.resp_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_q    <= ID_W'(NUM_REQ - 1);
            id_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cin_q   <= 1'b0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (any_valid) begin
                        a_q   <= bus.req_in1[int'(grant)*OP_W +: OP_W];
                        b_q   <= bus.req_in2[int'(grant)*OP_W +: OP_W];
                        cin_q <= bus.req_cin[grant];
                        rr_q  <= grant;
                        id_q  <= grant;
                        cnt_q <= '0;
                    end
                end
                ST_RUN: begin
                    sum_q[cnt_q] <= add_sum;
                    carry_q      <= add_cout;
                    if (last_chunk) begin
                        cout_q <= add_cout;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.resp_valid = (state_q == ST_DONE);
    assign bus.resp_id    = id_q;
    assign bus.resp_sum   = sum_q;
    assign bus.resp_cout  = cout_q;

endmodule

// File: tb/tb_multiword_add_sched.sv
// tb/tb_multiword_add_sched.sv - directed and randomized checks of the shared wide-adder scheduler
module tb_multiword_add_sched;

    localparam int CW = 32;
    localparam int NC = 2;
    localparam int NR = 2;
    localparam int OW = CW * NC;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    multiword_add_sched_if #(.CHUNK_W(CW), .NUM_CHUNKS(NC), .NUM_REQ(NR)) bus ();

    multiword_add_sched #(.CHUNK_W(CW), .NUM_CHUNKS(NC), .NUM_REQ(NR)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [OW-1:0] op_a [NR];
    logic [OW-1:0] op_b [NR];
    logic          op_c [NR];

    assign bus.req_in1 = {op_a[1], op_a[0]};
    assign bus.req_in2 = {op_b[1], op_b[0]};
    assign bus.req_cin = {op_c[1], op_c[0]};

    int checks   = 0;
    int failures = 0;
    int rr_model;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Round robin: first requester with valid set, searching forward from the one after last.
    function automatic int next_grant(input int last, input logic [NR-1:0] mask);
        for (int k = 1; k <= NR; k++) begin
            int i;
            i = (last + k) % NR;
            if (((mask >> i) & 1) != 0) return i;
        end
        return -1;
    endfunction

    function automatic logic [OW-1:0] rnd_op();
        int sel;
        sel = $urandom_range(0, 4);
        if (sel == 0) return '1;
        if (sel == 1) return '0;
        return {$urandom, $urandom};
    endfunction

    task automatic run_op(input string tag, input int hold, input bit keep, output int acc_cyc);
        int            g;
        int            lat;
        bit            busy_bad;
        logic [OW:0]   exp;
        g = next_grant(rr_model, bus.req_valid);
        #1;
        check({tag, "/ready"}, bus.req_ready, NR'(1) << g);
        exp      = {1'b0, op_a[g]} + {1'b0, op_b[g]} + (OW+1)'(op_c[g]);
        rr_model = g;
        acc_cyc  = cyc;
        tick();
        if (!keep) begin
            bus.req_valid = bus.req_valid & ~(NR'(1) << g);
            op_a[g] = {$urandom, $urandom};
            op_b[g] = {$urandom, $urandom};
            op_c[g] = ~op_c[g];
        end
        lat      = 1;
        busy_bad = 1'b0;
        while (bus.resp_valid !== 1'b1 && lat < 20) begin
            if (bus.req_ready !== '0) busy_bad = 1'b1;
            tick();
            lat++;
        end
        check({tag, "/latency"}, lat, NC + 1);
        check({tag, "/busy_ready"}, busy_bad, 0);
        for (int h = 0; h < hold; h++) begin
            #1;
            check({tag, "/hold"},
                  {bus.resp_valid, bus.req_ready, bus.resp_id, bus.resp_cout, bus.resp_sum},
                  {1'b1, 2'b00, g[0], exp[OW], exp[OW-1:0]});
            tick();
        end
        bus.resp_ready = 1'b1;
        #1;
        check({tag, "/sum"}, bus.resp_sum, exp[OW-1:0]);
        check({tag, "/cout"}, bus.resp_cout, exp[OW]);
        check({tag, "/id"}, bus.resp_id, g);
        check({tag, "/done_ready"}, bus.req_ready, 0);
        tick();
        bus.resp_ready = 1'b0;
    endtask

    task automatic reset_midop(input string tag, input logic [NR-1:0] mask);
        int g;
        bus.req_valid = mask;
        g = next_grant(rr_model, mask);
        #1;
        check({tag, "/ready"}, bus.req_ready, NR'(1) << g);
        tick();
        bus.req_valid = '0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        rr_model = NR - 1;
        #1;
        check({tag, "/post_rst"},
              {bus.req_ready, bus.resp_valid, bus.resp_id, bus.resp_cout, bus.resp_sum}, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            #1;
            check({tag, "/no_resp"}, bus.resp_valid, 0);
        end
        tick();
    endtask

    initial begin
        int acc, prev;
        rst            = 1'b1;
        bus.resp_ready = 1'b0;
        bus.req_valid  = 2'b11;
        for (int i = 0; i < NR; i++) begin
            op_a[i] = '0;
            op_b[i] = '0;
            op_c[i] = 1'b0;
        end
        rr_model = NR - 1;

        repeat (3) begin
            tick();
            #1;
            check("reset_outputs",
                  {bus.req_ready, bus.resp_valid, bus.resp_id, bus.resp_cout, bus.resp_sum}, 0);
        end

        op_a[0] = 64'h0000_0000_FFFF_FFFF;
        op_b[0] = 64'h1;
        op_c[0] = 1'b0;
        op_a[1] = 64'hFFFF_FFFF_FFFF_FFFF;
        op_b[1] = 64'h0;
        op_c[1] = 1'b1;
        rst = 1'b0;
        run_op("carry_chain_req0", 0, 1'b0, acc);
        run_op("wrap_req1", 0, 1'b0, acc);

        bus.req_valid = 2'b11;
        for (int i = 0; i < 4; i++) begin
            prev = acc;
            run_op("rr_alternate", 0, 1'b1, acc);
            if (i > 0) check("rr_spacing", acc - prev, NC + 2);
        end

        prev = acc;
        run_op("stall_done", 5, 1'b1, acc);
        prev = acc;
        run_op("after_stall", 0, 1'b1, acc);
        check("stall_resume", acc - prev, NC + 2 + 5);

        reset_midop("rst_after_req1", 2'b10);
        bus.req_valid = 2'b11;
        run_op("first_after_rst_a", 0, 1'b0, acc);
        reset_midop("rst_after_req0", 2'b01);
        bus.req_valid = 2'b11;
        run_op("first_after_rst_b", 0, 1'b0, acc);

        for (int i = 0; i < 10; i++) begin
            for (int r = 0; r < NR; r++) begin
                op_a[r] = rnd_op();
                op_b[r] = rnd_op();
                op_c[r] = 1'($urandom_range(0, 1));
            end
            bus.req_valid = NR'($urandom_range(1, 3));
            run_op("random", $urandom_range(0, 2), 1'b0, acc);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not complete checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
